// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer for a 4:1 single-bit multiplexer datapath.
// Four requesters share one output channel. One requester at a time is
// granted, the mux select pair {s0,s1} follows the granted index, and the
// selected data bit is registered onto y while the channel is owned.
//
// Optional feature (compile-time macro MUX4_ARB_TIMEOUT_EN):
//   When defined, a tenure is limited to HOLD_MAX consecutive GRANT cycles.
//   The owner is then forced off the channel and 'expired' pulses for one
//   cycle. When undefined, tenure is unbounded and the 'expired' port and
//   the hold counter do not exist.
//
// Parameters:
//   HOLD_MAX  maximum GRANT cycles per tenure with timeout enabled (2..255)
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   req      in   4  level request per requester
//   i        in   4  data bit per requester (i[k] belongs to requester k)
//   gnt      out  4  one-hot grant, all-zero when idle
//   s0       out  1  mux select MSB of the granted index
//   s1       out  1  mux select LSB of the granted index
//   busy     out  1  high while a requester owns the channel
//   y        out  1  registered i[idx] while busy, 0 otherwise
//   expired  out  1  one-cycle pulse on forced release (timeout build only)
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] i,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       y
`ifdef MUX4_ARB_TIMEOUT_EN
    ,
    output logic       expired
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] idx;     // current (or most recent) owner
    logic [1:0] last;    // most recently served requester, lowest priority next

`ifdef MUX4_ARB_TIMEOUT_EN
    // Counter value seen on the last permitted GRANT cycle of a tenure.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt;

    // Hold counter increment, sticking at the top of its range.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        sat_inc = (c == 8'hFF) ? c : c + 8'd1;
    endfunction
`endif

    // First set request searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // Scanning from the farthest candidate back to the nearest lets the
    // nearest set bit win without a priority chain of early exits.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [3:0] r);
        logic [1:0] cand;
        rr_pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (r[cand]) begin
                rr_pick = cand;
            end
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] n);
        onehot4 = 4'b0001 << n;
    endfunction

    logic [1:0] pick;
    logic       owner_req;
    logic       owner_bit;

    assign pick      = rr_pick(last, req);
    assign owner_req = req[idx];
    assign owner_bit = i[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            s0      <= 1'b0;
            s1      <= 1'b0;
            busy    <= 1'b0;
            y       <= 1'b0;
            idx     <= 2'd0;
            last    <= 2'd3;
`ifdef MUX4_ARB_TIMEOUT_EN
            cnt     <= 8'd0;
            expired <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    y <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
                    expired <= 1'b0;
`endif
                    if (|req) begin
                        state      <= GRANT;
                        idx        <= pick;
                        last       <= pick;
                        gnt        <= onehot4(pick);
                        {s0, s1}   <= pick;
                        busy       <= 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
                        cnt        <= 8'd0;
`endif
                    end
                end

                GRANT: begin
                    // A voluntary release takes precedence over the timeout,
                    // so an owner dropping on its final cycle sees no pulse.
                    // s0/s1 keep the last index across the release.
                    if (!owner_req) begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                        y     <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
                    end else if (cnt == HOLD_LAST) begin
                        state   <= IDLE;
                        gnt     <= 4'b0000;
                        busy    <= 1'b0;
                        y       <= 1'b0;
                        expired <= 1'b1;
`endif
                    end else begin
                        y <= owner_bit;
`ifdef MUX4_ARB_TIMEOUT_EN
                        cnt <= sat_inc(cnt);
`endif
                    end
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt));
    a_busy_gnt: assert property (@(posedge clk) disable iff (rst)
        busy == (gnt != 4'b0000));
    a_y_idle: assert property (@(posedge clk) disable iff (rst)
        !busy |-> !y);
    a_sel_idx: assert property (@(posedge clk) disable iff (rst)
        busy |-> (gnt == onehot4({s0, s1})));
    a_hold_range: assert property (@(posedge clk)
        (HOLD_MAX >= 2) && (HOLD_MAX <= 255));
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int HOLD = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] i;
    logic [3:0] gnt;
    logic       s0, s1, busy, y;
    logic       expired_dut;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .i       (i),
        .gnt     (gnt),
        .s0      (s0),
        .s1      (s1),
        .busy    (busy),
        .y       (y)
`ifdef MUX4_ARB_TIMEOUT_EN
        ,
        .expired (expired_dut)
`endif
    );

`ifndef MUX4_ARB_TIMEOUT_EN
    assign expired_dut = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic       s0;
        logic       s1;
        logic       busy;
        logic       y;
        logic       expired;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the channel, how long they have held it,
    // who was served last, and what the outputs should read after the edge.
    int m_owner  = -1;   // -1 means nobody owns the channel
    int m_last   = 3;
    int m_sel    = 0;
    int m_tenure = 0;    // busy cycles completed in the current tenure
    bit m_y      = 0;
    bit m_exp    = 0;

    task automatic model_edge(input logic r, input logic [3:0] rq,
                              input logic [3:0] dat);
        int c;
        if (r) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_tenure = 0;
            m_y = 0; m_exp = 0;
        end else if (m_owner < 0) begin
            m_y = 0; m_exp = 0;
            if (rq != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (rq[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner; m_sel = m_owner; m_tenure = 1;
            end
        end else begin
            m_exp = 0;
            if (!rq[m_owner]) begin
                m_owner = -1; m_y = 0;
            end else if (TIMEOUT_ON && m_tenure == HOLD) begin
                m_owner = -1; m_y = 0; m_exp = 1;
            end else begin
                m_tenure = m_tenure + 1;
                m_y = dat[m_owner];
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.gnt     = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        o.s0      = (m_sel / 2) != 0;
        o.s1      = (m_sel % 2) != 0;
        o.busy    = (m_owner >= 0);
        o.y       = m_y;
        o.expired = m_exp;
        return o;
    endfunction

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] dat);
        rst = r;
        req = rq;
        i   = dat;
        model_edge(r, rq, dat);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents a full set of registered outputs.
    initial begin
        obs_t act, want;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                act  = '{gnt: gnt, s0: s0, s1: s1, busy: busy, y: y,
                         expired: expired_dut};
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL outputs t=%0t got gnt=%b s0s1=%b%b busy=%b y=%b exp=%b want gnt=%b s0s1=%b%b busy=%b y=%b exp=%b",
                             $time, act.gnt, act.s0, act.s1, act.busy, act.y,
                             act.expired, want.gnt, want.s0, want.s1,
                             want.busy, want.y, want.expired);
                end
            end
        end
    end

    initial begin
        bit [3:0] want_req;
        logic [3:0] dat;
        // Reset with every requester asking, then first grant goes to 0.
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b0, 4'b1111, 4'b0001);
        step(1'b0, 4'b1111, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        // Single requester 2, data bit high.
        for (int n = 0; n < 4; n++) step(1'b0, 4'b0100, 4'b0100);
        step(1'b0, 4'b0000, 4'b0100);
        step(1'b0, 4'b0000, 4'b0000);
        // Everyone requesting; owners drop for one cycle after a short hold.
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 4'b1111, 4'b1010);
            step(1'b0, 4'b1111, 4'b0101);
            step(1'b0, 4'b1111 & ~(4'(1 << ((n + 1) % 4))), 4'b1111);
        end
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        // No preemption: owner 1 holds while requester 3 joins.
        step(1'b0, 4'b0010, 4'b0010);
        step(1'b0, 4'b0010, 4'b0010);
        for (int n = 0; n < 3; n++) step(1'b0, 4'b1010, 4'b0010);
        for (int n = 0; n < 3; n++) step(1'b0, 4'b1000, 4'b1000);
        // Reset in the middle of requester 3's tenure, then 0 goes first.
        step(1'b1, 4'b1000, 4'b1000);
        step(1'b0, 4'b1001, 4'b1001);
        step(1'b0, 4'b1001, 4'b1001);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        // Two requesters held for a long time: exercises the hold limit.
        for (int n = 0; n < 14; n++) step(1'b0, 4'b0101, 4'($urandom_range(0, 15)));
        step(1'b0, 4'b0000, 4'b0000);
        // One-cycle glitch in idle.
        step(1'b0, 4'b0100, 4'b0100);
        step(1'b0, 4'b0000, 4'b0100);
        step(1'b0, 4'b0000, 4'b0000);
        // Randomized traffic with occasional resets.
        want_req = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (want_req[k] && ($urandom % 5 == 0))
                    want_req[k] = 1'b0;
                else if (!want_req[k] && ($urandom % 3 == 0))
                    want_req[k] = 1'b1;
            end
            dat = 4'($urandom_range(0, 15));
            step(($urandom % 150) == 0, want_req, dat);
        end
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
